// File: rtl/dmem_wr_arbiter.sv
// Round-robin arbiter for the data memory's second write port. External writers
// win ownership for bursts of up to MAXBUR words; core port-A writes to the same address stall the stage.
module dmem_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int NUBITS = 16,
  parameter int MDATAS = 64,
  parameter int MDATAW = $clog2(MDATAS),
  parameter int MAXBUR = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            last,
  input  logic [NREQ*MDATAW-1:0]     addr,
  input  logic [NREQ*NUBITS-1:0]     data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       core_wra,
  input  logic [MDATAW-1:0]          core_addr_wa,
  output logic                       mem_wrb,
  output logic [MDATAW-1:0]          mem_addr_wb,
  output logic [NUBITS-1:0]          mem_data_inb,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       dbg_state,
  output logic [$clog2(NREQ)-1:0]    dbg_rr
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBUR + 1);

  // Handshake: a requester keeps req/last/addr/data stable while req is high;
  // the word is taken in the cycle its gnt bit is high, and not before.

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

  state_t              state, state_nx;
  logic [OW-1:0]       rr, rr_nx;
  logic [OW-1:0]       owner_nx;
  logic [CW-1:0]       cnt, cnt_nx, cnt_inc;
  logic                stv, stv_nx;
  logic                collide, stage_free, accept;
  logic                owner_req, owner_last;
  logic                found;
  logic [OW-1:0]       pick;
  logic [OW-1:0]       rr_inc;

  assign collide    = core_wra && (core_addr_wa == mem_addr_wb);
  assign mem_wrb    = stv && !collide;
  assign stage_free = !stv || mem_wrb;
  assign owner_req  = req[owner];
  assign owner_last = last[owner];
  assign accept     = (state == S_OWN) && owner_req && stage_free;
  assign cnt_inc    = cnt + 1'b1;
  assign rr_inc     = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign busy       = (state == S_OWN);
  assign dbg_state  = state;
  assign dbg_rr     = rr;

  // First requester at or after rr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(rr) + i) % NREQ]) begin
        found = 1'b1;
        pick  = OW'((int'(rr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr;
    cnt_nx   = cnt;
    gnt      = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          owner_nx = pick;
          cnt_nx   = '0;
          state_nx = S_OWN;
        end
      end
      S_OWN: begin
        if (!owner_req) begin
          state_nx = S_IDLE;
          rr_nx    = rr_inc;
        end else if (accept) begin
          gnt[owner] = 1'b1;
          cnt_nx     = cnt_inc;
          if (owner_last || (cnt_inc == CW'(MAXBUR))) begin
            state_nx = S_IDLE;
            rr_nx    = rr_inc;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A fresh accept refills the stage in the same cycle it drains.
  always_comb begin
    stv_nx = stv;
    if (accept)       stv_nx = 1'b1;
    else if (mem_wrb) stv_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      owner <= '0;
      rr    <= '0;
      cnt   <= '0;
      stv   <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      rr    <= rr_nx;
      cnt   <= cnt_nx;
      stv   <= stv_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_wb  <= '0;
      mem_data_inb <= '0;
    end else if (accept) begin
      mem_addr_wb  <= addr[owner*MDATAW +: MDATAW];
      mem_data_inb <= data[owner*NUBITS +: NUBITS];
    end
  end

endmodule

// File: tb/tb_dmem_wr_arbiter.sv
// Directed bench for dmem_wr_arbiter: per-cycle vector table plus hand sequences
// for round-robin rotation and reset during a stalled burst.
module tb_dmem_wr_arbiter;

  localparam int NREQ = 4;
  localparam int NUBITS = 16;
  localparam int MDATAW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main instance (MAXBUR=8)
  logic [NREQ-1:0]        req, last, gnt;
  logic [NREQ*MDATAW-1:0] addr;
  logic [NREQ*NUBITS-1:0] data;
  logic                   core_wra;
  logic [MDATAW-1:0]      core_addr_wa;
  logic                   m_wrb, busy, dbg_state;
  logic [MDATAW-1:0]      m_addr;
  logic [NUBITS-1:0]      m_data;
  logic [1:0]             owner, dbg_rr;

  // round-robin instance (MAXBUR=2)
  logic [NREQ-1:0]        r_req, r_gnt;
  logic                   r_wrb, r_busy, r_state;
  logic [MDATAW-1:0]      r_addr;
  logic [NUBITS-1:0]      r_data;
  logic [1:0]             r_owner, r_rr;

  dmem_wr_arbiter #(.NREQ(NREQ), .NUBITS(NUBITS), .MDATAS(64), .MDATAW(MDATAW), .MAXBUR(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .addr(addr), .data(data), .gnt(gnt),
    .core_wra(core_wra), .core_addr_wa(core_addr_wa), .mem_wrb(m_wrb), .mem_addr_wb(m_addr),
    .mem_data_inb(m_data), .busy(busy), .owner(owner), .dbg_state(dbg_state), .dbg_rr(dbg_rr)
  );

  dmem_wr_arbiter #(.NREQ(NREQ), .NUBITS(NUBITS), .MDATAS(64), .MDATAW(MDATAW), .MAXBUR(2)) u_rr (
    .clk(clk), .rst(rst), .req(r_req), .last('0), .addr(addr), .data(data), .gnt(r_gnt),
    .core_wra(1'b0), .core_addr_wa('0), .mem_wrb(r_wrb), .mem_addr_wb(r_addr),
    .mem_data_inb(r_data), .busy(r_busy), .owner(r_owner), .dbg_state(r_state), .dbg_rr(r_rr)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic        cwa;
    logic [5:0]  ca;
    logic [5:0]  a;
    logic [15:0] d;
    logic [3:0]  e_gnt;
    logic        e_busy;
    logic [1:0]  e_owner;
    logic [1:0]  e_rr;
    logic        e_wrb;
    logic [5:0]  e_maddr;
    logic [15:0] e_mdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vec[NV];
  logic [21:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic [3:0] rq, logic [3:0] ls, logic cw, logic [5:0] ca,
                              logic [5:0] a, logic [15:0] d, logic [3:0] eg, logic eb,
                              logic [1:0] eo, logic [1:0] err, logic ew, logic [5:0] ema,
                              logic [15:0] emd);
    vec_t v;
    v.req = rq; v.last = ls; v.cwa = cw; v.ca = ca; v.a = a; v.d = d;
    v.e_gnt = eg; v.e_busy = eb; v.e_owner = eo; v.e_rr = err;
    v.e_wrb = ew; v.e_maddr = ema; v.e_mdata = emd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester i sees the same address and data ^ (i << 12) so slice selection is visible.
  task automatic drive(input logic [3:0] rq, input logic [3:0] ls, input logic cw,
                       input logic [5:0] ca, input logic [5:0] a, input logic [15:0] d);
    req = rq; last = ls; core_wra = cw; core_addr_wa = ca;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*MDATAW +: MDATAW] = a;
      data[i*NUBITS +: NUBITS] = d ^ (16'(i) << 12);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every memory write of the main instance must match the queue head
  always @(negedge clk) begin
    if (rst && m_wrb) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr %0d data 0x%0h, none expected", m_addr, m_data);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if ({m_addr, m_data} !== e) begin
          n_fail++;
          $display("FAIL wr_order: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   m_addr, m_data, e[21:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    vec[0]  = mk(4'b0000, 4'b0000, 0, 0, 0,  16'h0000, 4'b0000, 0, 0, 0, 0, 0,  16'h0000);
    vec[1]  = mk(4'b0100, 4'b0000, 0, 0, 5,  16'h00A1, 4'b0000, 0, 0, 0, 0, 0,  16'h0000);
    vec[2]  = mk(4'b0100, 4'b0000, 0, 0, 5,  16'h00A1, 4'b0100, 1, 2, 0, 0, 0,  16'h0000);
    vec[3]  = mk(4'b0100, 4'b0000, 1, 3, 6,  16'h00A2, 4'b0100, 1, 2, 0, 1, 5,  16'h20A1);
    vec[4]  = mk(4'b0100, 4'b0100, 0, 0, 7,  16'h00A3, 4'b0100, 1, 2, 0, 1, 6,  16'h20A2);
    vec[5]  = mk(4'b0000, 4'b0000, 0, 0, 0,  16'h0000, 4'b0000, 0, 2, 3, 1, 7,  16'h20A3);
    vec[6]  = mk(4'b0000, 4'b0000, 0, 0, 0,  16'h0000, 4'b0000, 0, 2, 3, 0, 7,  16'h20A3);
    vec[7]  = mk(4'b0010, 4'b0000, 0, 0, 9,  16'h0055, 4'b0000, 0, 2, 3, 0, 7,  16'h20A3);
    vec[8]  = mk(4'b0010, 4'b0000, 0, 0, 9,  16'h0055, 4'b0010, 1, 1, 3, 0, 7,  16'h20A3);
    vec[9]  = mk(4'b0010, 4'b0000, 1, 9, 10, 16'h0066, 4'b0000, 1, 1, 3, 0, 9,  16'h1055);
    vec[10] = mk(4'b0010, 4'b0000, 1, 9, 10, 16'h0066, 4'b0000, 1, 1, 3, 0, 9,  16'h1055);
    vec[11] = mk(4'b0010, 4'b0010, 0, 0, 10, 16'h0066, 4'b0010, 1, 1, 3, 1, 9,  16'h1055);
    vec[12] = mk(4'b0000, 4'b0000, 0, 0, 0,  16'h0000, 4'b0000, 0, 1, 2, 1, 10, 16'h1066);
    vec[13] = mk(4'b0000, 4'b0000, 0, 0, 0,  16'h0000, 4'b0000, 0, 1, 2, 0, 10, 16'h1066);
    vec[14] = mk(4'b0010, 4'b0000, 0, 0, 20, 16'h0077, 4'b0000, 0, 1, 2, 0, 10, 16'h1066);
    vec[15] = mk(4'b1010, 4'b0000, 0, 0, 20, 16'h0077, 4'b0010, 1, 1, 2, 0, 10, 16'h1066);
    vec[16] = mk(4'b0000, 4'b0000, 0, 0, 0,  16'h0000, 4'b0000, 1, 1, 2, 1, 20, 16'h1077);
    vec[17] = mk(4'b0000, 4'b0000, 0, 0, 0,  16'h0000, 4'b0000, 0, 1, 2, 0, 20, 16'h1077);
    exp_q.push_back({6'd5,  16'h20A1});
    exp_q.push_back({6'd6,  16'h20A2});
    exp_q.push_back({6'd7,  16'h20A3});
    exp_q.push_back({6'd9,  16'h1055});
    exp_q.push_back({6'd10, 16'h1066});
    exp_q.push_back({6'd20, 16'h1077});

    drive(4'b0000, 4'b0000, 0, 0, 0, 16'h0000);
    r_req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wrb", {31'd0, m_wrb}, 32'd0);
    chk("reset_owner", {30'd0, owner}, 32'd0);
    rst = 1'b1;

    // round-robin on the MAXBUR=2 instance: two grants per owner, one idle cycle between
    r_req = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("rr_gnt", {28'd0, r_gnt}, (k % 3 == 0) ? 32'd0 : (32'd1 << ((k / 3) % 4)));
      chk("rr_busy", {31'd0, r_busy}, (k % 3 == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    r_req = 4'b0000;
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].req, vec[i].last, vec[i].cwa, vec[i].ca, vec[i].a, vec[i].d);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i),   {28'd0, gnt},    {28'd0, vec[i].e_gnt});
      chk($sformatf("v%0d_busy", i),  {31'd0, busy},   {31'd0, vec[i].e_busy});
      chk($sformatf("v%0d_owner", i), {30'd0, owner},  {30'd0, vec[i].e_owner});
      chk($sformatf("v%0d_rr", i),    {30'd0, dbg_rr}, {30'd0, vec[i].e_rr});
      chk($sformatf("v%0d_wrb", i),   {31'd0, m_wrb},  {31'd0, vec[i].e_wrb});
      chk($sformatf("v%0d_maddr", i), {26'd0, m_addr}, {26'd0, vec[i].e_maddr});
      chk($sformatf("v%0d_mdata", i), {16'd0, m_data}, {16'd0, vec[i].e_mdata});
      next_cycle();
    end

    // reset while a word is held in the stage by a core collision
    drive(4'b1000, 4'b0000, 0, 0, 30, 16'h0088);
    @(negedge clk);
    chk("mr_idle_gnt", {28'd0, gnt}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("mr_gnt", {28'd0, gnt}, 32'h8);
    chk("mr_owner", {30'd0, owner}, 32'd3);
    next_cycle();
    drive(4'b1000, 4'b0000, 1, 30, 31, 16'h0099);
    @(negedge clk);
    chk("mr_hold_wrb", {31'd0, m_wrb}, 32'd0);
    chk("mr_hold_addr", {26'd0, m_addr}, 32'd30);
    chk("mr_hold_gnt", {28'd0, gnt}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mr_rst_wrb", {31'd0, m_wrb}, 32'd0);
    chk("mr_rst_busy", {31'd0, busy}, 32'd0);
    chk("mr_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mr_rst_addr", {26'd0, m_addr}, 32'd0);
    next_cycle();
    drive(4'b0000, 4'b0000, 0, 0, 0, 16'h0000);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mr_after_wrb", {31'd0, m_wrb}, 32'd0);
      chk("mr_after_owner", {30'd0, owner}, 32'd0);
      chk("mr_after_busy", {31'd0, busy}, 32'd0);
      next_cycle();
    end

    chk("wr_pending", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_wr_arbiter.md
# dmem_wr_arbiter

Round-robin arbiter that shares the data memory's second write port (`wrb` / `addr_wb` / `data_inb` of `mem_data`) among `NREQ` external writers, such as DMA engines, debug loaders and peripheral FIFOs. The core's own port A keeps absolute priority: the arbiter holds its staged write in any cycle where the core writes the same address. A granted requester owns the port for a burst of up to `MAXBUR` words. The block sits beside `processor`, between the writers and `mdata`.

## Interface

Parameters:

- `NREQ`, 4: number of requesters (≥2)
- `NUBITS`, 16: data word width, equal to the processor word
- `MDATAS`, 64: data memory size
- `MDATAW`, `$clog2(MDATAS)`: address width
- `MAXBUR`, 8: maximum words per ownership (≥1)

Ports:

- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `req` in `NREQ`: per-requester write request; word valid while high
- `last` in `NREQ`: marks the presented word as the final word of the burst
- `addr` in `NREQ*MDATAW`: per-requester word address; requester i uses slice [i*MDATAW +: MDATAW]
- `data` in `NREQ*NUBITS`: per-requester write data, sliced the same way
- `gnt` out `NREQ`: one-hot; high in the cycle requester i's word is accepted
- `core_wra` in 1: core port-A write enable (`mem_wra`)
- `core_addr_wa` in `MDATAW`: core port-A write address
- `mem_wrb` out 1: to `mdata.wrb`
- `mem_addr_wb` out `MDATAW`: to `mdata.addr_wb`
- `mem_data_inb` out `NUBITS`: to `mdata.data_inb`
- `busy` out 1: high while state is OWN
- `owner` out `$clog2(NREQ)`: index of the current or last owner

## Operation

State machine with two states, IDLE and OWN. There is also a pointer `rr` of `$clog2(NREQ)` bits, a word counter `cnt` of `$clog2(MAXBUR+1)` bits, and a one-entry output stage (`stv` plus an address/data register).

IDLE:
- Scan `req` starting at `rr`, wrapping modulo `NREQ`.
- The first requester found becomes `owner`. Set `cnt`=0 and move to OWN next cycle.
- No `gnt` is issued in IDLE.
- With no requests, stay in IDLE.

OWN:
- Accept condition: `req[owner]` is high and the stage is free. The stage is free when `stv`=0, or when the stage drains this cycle (`mem_wrb`=1).
- On accept: `gnt[owner]`=1 (combinational), load the stage from the owner's address and data slices, set `stv`=1, and increment `cnt`.
- Release OWN and go to IDLE, with `rr` = `owner`+1 (mod `NREQ`), when any of these is true:
  - a word is accepted with `last[owner]`=1;
  - a word is accepted and `cnt` reaches `MAXBUR`;
  - `req[owner]` is low.
- Non-owner requests are ignored until release. Their `gnt` stays 0 and they must hold their word.

Output stage:
- `mem_wrb` = `stv` & ~(`core_wra` & `core_addr_wa`==`mem_addr_wb`).
- On a collision the stage holds and retries every cycle. No word is dropped and none is written twice.
- The stage clears when `mem_wrb`=1 and no new word is accepted that cycle.
- The stage drains independently of state, so a word staged just before release still writes while in IDLE.

Address handling:
- Addresses pass through unmodified. Wrap-around is the requester's responsibility.
- No range check is made; `MDATAW` bits already cover the array.

## Timing

- Reset (async assert, sync release) sets: IDLE, `rr`=0, `cnt`=0, `stv`=0, `mem_wrb`=0, `mem_addr_wb`=0, `mem_data_inb`=0, `gnt`=0, `busy`=0, `owner`=0.
- Reset mid-burst discards any staged word (it is not written) and drops ownership.
- Arbitration latency: `req` rising in IDLE at cycle n gives `busy`=1 at n+1 and the first `gnt` at n+1.
- Write latency: word accepted at cycle n gives `mem_wrb`=1 at n+1 if there is no collision. It reaches memory at the n+1 clock edge.
- Throughput: 1 word/cycle in OWN while there are no collisions.
- Handover: one IDLE cycle between owners, so at most `MAXBUR` words per 1+`MAXBUR` cycles per owner.
- Simultaneous events:
  - `last` and the `MAXBUR` limit on the same word cause a single release.
  - A collision while the owner presents a word deasserts `gnt`; the requester holds.
- `gnt` is purely combinational from state, `stv`, `req`, and the collision compare. All other outputs except `mem_wrb` are registered.

## Test plan

- Reset then single writer: `req[2]`=1 with addresses 5,6,7 (data 0xA1,0xA2,0xA3), `last` on the third word. Expect `busy` at cycle 1, `gnt[2]` on cycles 1–3, `mem_wrb` on cycles 2–4 with matching address/data, then IDLE and `rr`=3.
- Round-robin: all four `req` held high with no `last`, `MAXBUR`=2. Expect owner order 0,1,2,3,0; each owner gets exactly 2 `gnt` pulses with one IDLE gap between owners.
- Collision: owner's staged word at address 9 while `core_wra`=1 and `core_addr_wa`=9 for 2 cycles. Expect `mem_wrb`=0 for those cycles, the stage held, `gnt`=0, and the write to 9 issued the cycle after the core stops. Memory ends with the arbiter's data.
- Request drop: owner 1 deasserts `req` after 1 word. Expect release, `rr`=2, and its staged word still written one cycle later.
- Reset mid-burst: `rst` low while `stv`=1. Expect `mem_wrb`, `busy`, and `gnt` at 0 immediately, the staged word never written, and `owner`=0 after release.
